// File: rtl/game_pkg.sv
// Shared encodings for the round scoreboard:
// round-result codes and the match FSM state type.
package game_pkg;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_WIN  = 2'b01;
  localparam logic [1:0] WHO_LOSE = 2'b10;
  localparam logic [1:0] WHO_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    SCORE,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/hold_timer.sv
// Down-counter that spaces a round end from the restart pulse.
// load arms it with HOLD_CYCLES; expire flags the last hold cycle.
module hold_timer #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0] cnt;

  // load wins; otherwise count down while enabled, stopping at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(HOLD_CYCLES);
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/game_scoreboard.sv
// Best-of match scoreboard sequencing rounds of a game.
// Optional SCOREBOARD_HISTORY_EN adds a per-round who log.
module game_scoreboard
  import game_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       gameover_i,
  input  logic [1:0] who_i,
  output logic       round_restart_o,
  output logic [2:0] win_rounds_o,
  output logic [2:0] lose_rounds_o,
  output logic       match_done_o,
  output logic [1:0] match_winner_o,
  output logic       busy_o
`ifdef SCOREBOARD_HISTORY_EN
  ,
  output logic [2*(2*ROUNDS_TO_WIN-1)-1:0] history_o
`endif
);

  localparam logic [2:0] TARGET = 3'(ROUNDS_TO_WIN);

  state_t     state_q;
  state_t     state_d;
  logic       go_q;
  logic       rise;
  logic [1:0] who_q;
  logic [1:0] who_d;
  logic [2:0] win_q;
  logic [2:0] win_d;
  logic [2:0] win_inc;
  logic [2:0] lose_q;
  logic [2:0] lose_d;
  logic [2:0] lose_inc;
  logic [1:0] winner_q;
  logic [1:0] winner_d;
  logic       restart;
  logic       t_load;
  logic       t_en;
  logic       t_expire;

  assign rise = gameover_i & ~go_q;

  assign win_inc =
    (who_q == WHO_WIN && win_q != TARGET) ?
    win_q + 3'd1 : win_q;

  assign lose_inc =
    (who_q == WHO_LOSE && lose_q != TARGET) ?
    lose_q + 3'd1 : lose_q;

  assign t_en = (state_q == HOLD);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst),
    .load  (t_load),
    .en    (t_en),
    .expire(t_expire)
  );

  // match sequencing: next state, score updates, restart pulse
  always_comb begin
    state_d  = state_q;
    who_d    = who_q;
    win_d    = win_q;
    lose_d   = lose_q;
    winner_d = winner_q;
    restart  = 1'b0;
    t_load   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          restart  = 1'b1;
          win_d    = '0;
          lose_d   = '0;
          winner_d = WHO_NONE;
          who_d    = WHO_NONE;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (rise) begin
          who_d   = who_i;
          state_d = SCORE;
        end
      end
      SCORE: begin
        win_d  = win_inc;
        lose_d = lose_inc;
        if (win_inc == TARGET) begin
          winner_d = WHO_WIN;
          state_d  = DONE;
        end else if (lose_inc == TARGET) begin
          winner_d = WHO_LOSE;
          state_d  = DONE;
        end else begin
          t_load  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (t_expire) begin
          restart = 1'b1;
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, edge detector and score registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      go_q     <= 1'b0;
      who_q    <= WHO_NONE;
      win_q    <= '0;
      lose_q   <= '0;
      winner_q <= WHO_NONE;
    end else begin
      state_q  <= state_d;
      go_q     <= gameover_i;
      who_q    <= who_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      winner_q <= winner_d;
    end
  end

  assign round_restart_o = restart & rst;
  assign win_rounds_o    = win_q;
  assign lose_rounds_o   = lose_q;
  assign match_winner_o  = winner_q;
  assign match_done_o    = (state_q == DONE);
  assign busy_o          = (state_q == PLAY)
                        || (state_q == SCORE)
                        || (state_q == HOLD);

`ifdef SCOREBOARD_HISTORY_EN
  localparam int HW = 2*(2*ROUNDS_TO_WIN-1);

  logic [HW-1:0] hist_q;
  logic          clr;

  assign clr = start_i
            && (state_q == IDLE || state_q == DONE);

  // shift each scored round's who in at the LSBs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
    end else if (state_q == SCORE) begin
      hist_q <= (hist_q << 2) | HW'(who_q);
    end
  end

  assign history_o = hist_q;
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
// Randomized + directed bench for game_scoreboard
// against an event-scheduled match model.
module tb_game_scoreboard;

  localparam int R  = 2;
  localparam int H  = 4;
  localparam int HW = 2*(2*R-1);

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       gameover_i;
  logic [1:0] who_i;
  logic       round_restart_o;
  logic [2:0] win_rounds_o;
  logic [2:0] lose_rounds_o;
  logic       match_done_o;
  logic [1:0] match_winner_o;
  logic       busy_o;
`ifdef SCOREBOARD_HISTORY_EN
  logic [HW-1:0] history_o;
`endif

  game_scoreboard #(
    .ROUNDS_TO_WIN(R),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .gameover_i     (gameover_i),
    .who_i          (who_i),
    .round_restart_o(round_restart_o),
    .win_rounds_o   (win_rounds_o),
    .lose_rounds_o  (lose_rounds_o),
    .match_done_o   (match_done_o),
    .match_winner_o (match_winner_o),
    .busy_o         (busy_o)
`ifdef SCOREBOARD_HISTORY_EN
    ,
    .history_o      (history_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int npulse = 0;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // match model: scores plus scheduled score/restart cycles
  int         t = 0;
  int         m_win = 0;
  int         m_lose = 0;
  logic [1:0] m_winner = 2'b00;
  bit         m_done = 0;
  bit         m_active = 0;
  bit         m_armed = 0;
  bit         m_prev = 0;
  int         m_score_t = -1;
  int         m_restart_t = -1;
  logic [1:0] m_who = 2'b00;
  logic [HW-1:0] m_hist = '0;

  always @(negedge clk) begin
    bit start_ok;
    bit e_restart;
    if (round_restart_o) npulse++;
    if (!rst) begin
      m_win = 0; m_lose = 0; m_winner = 2'b00;
      m_done = 0; m_active = 0; m_armed = 0;
      m_score_t = -1; m_restart_t = -1;
      m_hist = '0;
      check("rst_restart", round_restart_o, 0);
      check("rst_win", win_rounds_o, 0);
      check("rst_lose", lose_rounds_o, 0);
      check("rst_done", match_done_o, 0);
      check("rst_winner", match_winner_o, 0);
      check("rst_busy", busy_o, 0);
    end else begin
      start_ok  = start_i && !m_active;
      e_restart = start_ok || (t == m_restart_t);
      check("restart", round_restart_o, e_restart);
      check("win", win_rounds_o, 8'(m_win));
      check("lose", lose_rounds_o, 8'(m_lose));
      check("done", match_done_o, m_done);
      check("winner", match_winner_o, m_winner);
      check("busy", busy_o, m_active);
`ifdef SCOREBOARD_HISTORY_EN
      check("hist", 8'(history_o), 8'(m_hist));
`endif
      if (start_ok) begin
        m_win = 0; m_lose = 0; m_winner = 2'b00;
        m_done = 0; m_active = 1; m_armed = 1;
        m_score_t = -1; m_restart_t = -1;
        m_hist = '0;
      end else if (m_active) begin
        if (m_armed && gameover_i && !m_prev) begin
          m_armed   = 0;
          m_score_t = t + 1;
          m_who     = who_i;
        end
        if (t == m_score_t) begin
          m_score_t = -1;
          if (m_who == 2'b01 && m_win < R) m_win++;
          if (m_who == 2'b10 && m_lose < R) m_lose++;
          m_hist = (m_hist << 2) | HW'(m_who);
          if (m_win == R || m_lose == R) begin
            m_done   = 1;
            m_active = 0;
            m_winner = (m_win == R) ? 2'b01 : 2'b10;
          end else begin
            m_restart_t = t + 1 + H;
          end
        end
        if (t == m_restart_t) begin
          m_armed     = 1;
          m_restart_t = -1;
        end
      end
    end
    m_prev = rst ? gameover_i : 1'b0;
    t++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gameover edge now; restart expected exactly 6 cycles on
  task automatic round(input logic [1:0] w, input bit last);
    gameover_i = 1'b1;
    who_i      = w;
    for (int k = 0; k <= 8; k++) begin
      #1;
      check("rr_lat", round_restart_o, (!last && k == 6));
      tick;
      if (k == 1) gameover_i = 1'b0;
    end
  endtask

  int p0;

  initial begin
    rst = 1'b1; start_i = 1'b0;
    gameover_i = 1'b0; who_i = 2'b00;
    #1 rst = 1'b0;
    tick; tick; tick;
    #1;
    check("lit_rst_busy", busy_o, 0);
    check("lit_rst_win", win_rounds_o, 0);
    rst = 1'b1;
    p0 = npulse;
    tick; tick; tick;
    check("lit_no_rel_pulse", 8'(npulse - p0), 0);

    // two winning rounds
    p0 = npulse;
    start_i = 1'b1;
    #1 check("lit_start_pulse", round_restart_o, 1);
    tick; start_i = 1'b0;
    round(2'b01, 0);
    check("lit_win1", win_rounds_o, 1);
    round(2'b01, 1);
    #1;
    check("lit_win2", win_rounds_o, 2);
    check("lit_done", match_done_o, 1);
    check("lit_winner", match_winner_o, 2'b01);
    check("lit_busy_done", busy_o, 0);
    check("lit_pulses", 8'(npulse - p0), 2);

    // restart from DONE
    start_i = 1'b1;
    #1 check("lit_done_start", round_restart_o, 1);
    tick; start_i = 1'b0;
    #1;
    check("lit_clr_win", win_rounds_o, 0);
    check("lit_clr_done", match_done_o, 0);

    // void round
    round(2'b11, 0);
    check("lit_void_win", win_rounds_o, 0);
    check("lit_void_lose", lose_rounds_o, 0);
`ifdef SCOREBOARD_HISTORY_EN
    check("lit_void_hist", 8'(history_o[1:0]), 3);
`endif

    // gameover held across HOLD into PLAY
    gameover_i = 1'b1; who_i = 2'b10;
    repeat (12) tick;
    check("lit_held_lose", lose_rounds_o, 1);
    gameover_i = 1'b0;
    tick;
    round(2'b10, 1);
    check("lit_held_lose2", lose_rounds_o, 2);
    check("lit_held_winner", match_winner_o, 2'b10);

    // reset during HOLD at 1-0
    start_i = 1'b1; tick; start_i = 1'b0;
    gameover_i = 1'b1; who_i = 2'b01;
    tick; gameover_i = 1'b0;
    tick; tick;
    check("lit_pre_rst_win", win_rounds_o, 1);
    rst = 1'b0;
    #1;
    check("lit_mid_rst_win", win_rounds_o, 0);
    check("lit_mid_rst_busy", busy_o, 0);
    tick; tick;
    rst = 1'b1;
    p0 = npulse;
    repeat (10) tick;
    check("lit_post_rst_pulse", 8'(npulse - p0), 0);
    start_i = 1'b1; tick; start_i = 1'b0;
    check("lit_restart_win", win_rounds_o, 0);
    check("lit_restart_busy", busy_o, 1);

    // start in PLAY ignored
    tick;
    start_i = 1'b1;
    #1 check("lit_play_start", round_restart_o, 0);
    tick; start_i = 1'b0;
    check("lit_play_busy", busy_o, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      tick;
      if (!rst) rst = 1'b1;
      else rst = ($urandom_range(0, 399) != 0);
      start_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) gameover_i = ~gameover_i;
      who_i = 2'($urandom_range(0, 3));
    end
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 SHALL have parameter ROUNDS_TO_WIN, default 3, meaning round wins needed to end a match (range 1..7).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, meaning cycles between a round end and the restart pulse (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: level, begins a match.
REQ-006 SHALL have port gameover_i, input, 1 bit: level from the game top, high while a round is finished.
REQ-007 SHALL have port who_i, input, 2 bits: round result; 2'b01 = winner side, 2'b10 = loser side, other values invalid.
REQ-008 SHALL have port round_restart_o, output, 1 bit: single-cycle pulse that re-arms the game (drives INIT and the game reset).
REQ-009 SHALL have port win_rounds_o, output, 3 bits: rounds won by the winner side.
REQ-010 SHALL have port lose_rounds_o, output, 3 bits: rounds won by the loser side.
REQ-011 SHALL have port match_done_o, output, 1 bit: level, high in the DONE state.
REQ-012 SHALL have port match_winner_o, output, 2 bits: who_i encoding of the match winner; 2'b00 until the match is decided.
REQ-013 SHALL have port busy_o, output, 1 bit: high in every state except IDLE and DONE.

Function
REQ-014 SHALL implement the FSM states IDLE, PLAY, SCORE, HOLD and DONE.
REQ-015 IDLE: on start_i=1 SHALL clear both scores, pulse round_restart_o in the same cycle, and go to PLAY next cycle.
REQ-016 PLAY: SHALL detect the gameover_i rising edge (registered previous value), latch who_i in that cycle, and go to SCORE; a gameover_i held high from a prior round SHALL NOT retrigger.
REQ-017 SCORE (one cycle): SHALL increment the latched side's score, applied at the end of SCORE; an invalid who SHALL leave scores unchanged (void round).
REQ-018 SCORE exit: if a score equals ROUNDS_TO_WIN, SHALL go to DONE and set match_winner_o; otherwise SHALL go to HOLD.
REQ-019 HOLD: SHALL count HOLD_CYCLES cycles, then assert round_restart_o for exactly one cycle and return to PLAY.
REQ-020 Latency from the gameover_i rising edge to the restart pulse SHALL be exactly 2+HOLD_CYCLES cycles.
REQ-021 DONE: SHALL hold scores and match_winner_o; start_i=1 SHALL behave as in IDLE (new match, same-cycle restart pulse).
REQ-022 start_i SHALL be ignored in PLAY, SCORE and HOLD.
REQ-023 gameover_i edges SHALL be ignored in IDLE, SCORE, HOLD and DONE.
REQ-024 Score counters SHALL saturate at ROUNDS_TO_WIN and never wrap.

Reset
REQ-025 rst low SHALL immediately force IDLE, clear both scores, set match_winner_o=2'b00, drive round_restart_o, match_done_o and busy_o low, clear the hold timer, and clear the edge-detect register.
REQ-026 Reset asserted mid-match SHALL discard all progress; no restart pulse SHALL be generated on reset release.

Configuration
REQ-027 With macro SCOREBOARD_HISTORY_EN defined, SHALL add output history_o [2*(2*ROUNDS_TO_WIN-1)-1:0]: each SCORE cycle shifts in the latched who (voids included) at the LSBs, the oldest entry drops off, and history_o is cleared by reset and by match start.
REQ-028 Without SCOREBOARD_HISTORY_EN, the history_o port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Shared package game_pkg SHALL hold the who encoding constants (WHO_NONE, WHO_WIN, WHO_LOSE, WHO_BAD) and the FSM state enum typedef.
REQ-030 The hold counter SHALL be a sub-module, hold_timer (load/expire interface, width from HOLD_CYCLES).

Verification (ROUNDS_TO_WIN=2, HOLD_CYCLES=4)
REQ-031 Start, then two rounds with who=01 -> win_rounds_o 1 then 2; match_done_o=1; match_winner_o=01; exactly 2 restart pulses (start + after round 1).
REQ-032 gameover_i rising at cycle N -> round_restart_o high only at cycle N+6.
REQ-033 who=11 at gameover -> scores unchanged, restart still issued; with SCOREBOARD_HISTORY_EN, history_o[1:0]=11.
REQ-034 gameover_i held high across HOLD and back into PLAY -> no second score; a later genuine edge scores normally.
REQ-035 rst low during HOLD with score 1-0 -> all outputs zero, no pulse after release; start_i then begins at 0-0.
REQ-036 start_i pulsed in PLAY -> ignored; in DONE -> scores clear, restart pulse in the same cycle.
